drop_tick_scheduler: RTL and testbench
======================================

Name: drop_tick_scheduler

Overview:
- Single-clock-domain scheduler that replaces derived slow/fast block-down clocks with one-cycle enable pulses on the system clock.
- Chooses the active gravity period from the game level and the soft-drop request.
- Sequences run, pause and lock-delay phases, and issues drop_tick and lock_tick pulses to the falling-piece controller.

Parameters:
- CNT_W, 28: width of the period counter and the period arithmetic.
- BASE_PERIOD, 33554432: gravity period in cycles at level 0.
- MIN_PERIOD, 4194304: floor on the level-derived gravity period.
- SOFT_PERIOD, 4194304: period in cycles while soft_drop is held.
- LOCK_PERIOD, 16777216: lock-delay length in cycles after landing.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that begins a game.
- stop, input, 1: one-cycle pulse that ends a game.
- pause_toggle, input, 1: one-cycle pulse that toggles pause.
- soft_drop, input, 1: level signal, held while the down key is pressed.
- level, input, 4: game level, 0 to 15.
- landed, input, 1: level signal, high while the piece rests on the stack.
- drop_tick, output, 1: one-cycle pulse that moves the piece down one row.
- lock_tick, output, 1: one-cycle pulse that commits the piece.
- running, output, 1: high in RUN or LOCK.
- paused, output, 1: high in PAUSE.
- state, output, 2: 0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = LOCK.

Behaviour:
- Reset (async assert, sync release): state = IDLE, cnt = 0, resume_state = RUN; all outputs 0.
- Period selection (combinational, CNT_W bits):
  - gperiod = max(BASE_PERIOD >> level, MIN_PERIOD).
  - period = SOFT_PERIOD when soft_drop = 1, otherwise gperiod.
- Command priority, evaluated each cycle: stop > start > pause_toggle. Lower-priority commands in the same cycle are ignored.
- IDLE:
  - start -> RUN with cnt = 0.
  - All other inputs are ignored.
- RUN:
  - cnt increments each cycle.
  - When cnt >= period - 1: drop_tick = 1 for one cycle and cnt = 0.
  - The >= comparison ensures that a period shrink mid-count (level rise, or soft_drop asserting) fires on the next cycle instead of wrapping.
  - landed = 1 -> LOCK with cnt = 0. No drop_tick is issued in that cycle, even if the terminal count was reached.
- LOCK:
  - cnt increments each cycle.
  - drop_tick is suppressed.
  - landed falls -> RUN with cnt = 0.
  - cnt = LOCK_PERIOD - 1 -> lock_tick = 1 for one cycle, cnt = 0, next state RUN. landed is ignored in the expiry cycle.
- PAUSE:
  - Entered from RUN or LOCK on pause_toggle. resume_state records the source state.
  - cnt is frozen.
  - pause_toggle -> return to resume_state with cnt intact.
- stop in any state -> IDLE with cnt = 0. Any pulse in that cycle is suppressed.
- start while in RUN, LOCK or PAUSE restarts the game: RUN with cnt = 0.
- Output timing:
  - drop_tick and lock_tick are registered and appear the cycle after the terminal count.
  - drop_tick and lock_tick are never both high in the same cycle.
  - running, paused and state are decoded from the state register.
- Arithmetic: all comparisons are unsigned at CNT_W bits. Parameters must satisfy SOFT_PERIOD, MIN_PERIOD, LOCK_PERIOD >= 2 and all < 2^CNT_W.

Optional Feature:
- Macro: DROP_TICK_COUNT_EN.
- When defined:
  - Adds output drop_count [15:0].
  - drop_count increments on every drop_tick and saturates at 16'hFFFF.
  - drop_count clears on reset and on start.
  - Used for soft-drop scoring.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
1. Sim parameters BASE_PERIOD=64, MIN_PERIOD=8, SOFT_PERIOD=4, LOCK_PERIOD=10; level=0, pulse start -> drop_tick every 64 cycles, running=1, state=1.
2. level=4 (64>>4=4, clamped to 8) -> drop_tick period 8. level 0 -> 3 when cnt=20 -> drop_tick on the next cycle, then period 8.
3. Hold soft_drop for 20 cycles -> drop_tick every 4 cycles. On release, period returns to the gperiod for the current level.
4. landed=1 held -> state=3, no drop_tick, lock_tick exactly 10 cycles after entry, then state=1. Repeat with landed dropped after 5 cycles -> state=1, no lock_tick.
5. pause_toggle at cnt=30 in RUN -> paused=1, no ticks for 100 cycles. pause_toggle again -> first drop_tick 34 cycles later. Pause from LOCK resumes into LOCK.
6. Priority and reset:
   - stop and pause_toggle in the same cycle -> IDLE.
   - rst_n low mid-LOCK -> all outputs 0 immediately (asynchronous).
   - With DROP_TICK_COUNT_EN defined, drop_count clears on start and counts 3 after 3 ticks.

Source files
------------

// File: rtl/drop_tick_scheduler.sv
// rtl/drop_tick_scheduler.sv - gravity/lock-delay tick scheduler producing one-cycle enables on the system clock
// Optional drop counter output enabled by defining DROP_TICK_COUNT_EN.
module drop_tick_scheduler #(
    parameter int CNT_W       = 28,
    parameter int BASE_PERIOD = 33554432,
    parameter int MIN_PERIOD  = 4194304,
    parameter int SOFT_PERIOD = 4194304,
    parameter int LOCK_PERIOD = 16777216
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause_toggle,
    input  logic        soft_drop,
    input  logic [3:0]  level,
    input  logic        landed,
    output logic        drop_tick,
    output logic        lock_tick,
    output logic        running,
    output logic        paused,
    output logic [1:0]  state
`ifdef DROP_TICK_COUNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LOCK  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] SOFT_C    = CNT_W'(SOFT_PERIOD);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_e            state_q, state_d;
    state_e            resume_q, resume_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_tick_q, drop_tick_d;
    logic              lock_tick_q, lock_tick_d;
    logic [CNT_W-1:0]  gshift, gperiod, period, period_last;

    always_comb begin
        gshift      = BASE_C >> level;
        gperiod     = (gshift > MIN_C) ? gshift : MIN_C;
        period      = soft_drop ? SOFT_C : gperiod;
        period_last = period - ONE_C;
    end

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        cnt_d       = cnt_q;
        drop_tick_d = 1'b0;
        lock_tick_d = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (pause_toggle) begin
                        state_d  = ST_PAUSE;
                        resume_d = ST_RUN;
                    end else if (landed) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q >= period_last) begin
                        // >= so a period that shrinks below cnt fires now rather than wrapping
                        drop_tick_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                ST_LOCK: begin
                    if (pause_toggle) begin
                        state_d  = ST_PAUSE;
                        resume_d = ST_LOCK;
                    end else if (cnt_q == LOCK_LAST) begin
                        lock_tick_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_RUN;
                    end else if (!landed) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                ST_PAUSE: begin
                    if (pause_toggle) begin
                        state_d = resume_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            resume_q    <= ST_RUN;
            cnt_q       <= '0;
            drop_tick_q <= 1'b0;
            lock_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            cnt_q       <= cnt_d;
            drop_tick_q <= drop_tick_d;
            lock_tick_q <= lock_tick_d;
        end
    end

`ifdef DROP_TICK_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (!stop && start) begin
            drop_count_d = '0;
        end else if (drop_tick_d && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign drop_tick = drop_tick_q;
    assign lock_tick = lock_tick_q;
    assign running   = (state_q == ST_RUN) || (state_q == ST_LOCK);
    assign paused    = (state_q == ST_PAUSE);
    assign state     = state_q;

endmodule

// File: tb/tb_drop_tick_scheduler.sv
// tb/tb_drop_tick_scheduler.sv - directed self-checking bench for drop_tick_scheduler
module tb_drop_tick_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        pause_toggle;
    logic        soft_drop;
    logic [3:0]  level;
    logic        landed;
    logic        drop_tick;
    logic        lock_tick;
    logic        running;
    logic        paused;
    logic [1:0]  state;
`ifdef DROP_TICK_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks;
    int errors;

    drop_tick_scheduler #(
        .CNT_W       (28),
        .BASE_PERIOD (64),
        .MIN_PERIOD  (8),
        .SOFT_PERIOD (4),
        .LOCK_PERIOD (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .pause_toggle (pause_toggle),
        .soft_drop    (soft_drop),
        .level        (level),
        .landed       (landed),
        .drop_tick    (drop_tick),
        .lock_tick    (lock_tick),
        .running      (running),
        .paused       (paused),
        .state        (state)
`ifdef DROP_TICK_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_drop(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!drop_tick && n <= max);
    endtask

    task automatic wait_lock(input int max, output int n, output int drops);
        n = 0;
        drops = 0;
        do begin
            step();
            n++;
            if (drop_tick) drops++;
        end while (!lock_tick && n <= max);
    endtask

    task automatic count_ticks(input int cycles, output int drops, output int locks);
        drops = 0;
        locks = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (drop_tick) drops++;
            if (lock_tick) locks++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({state, running, paused, drop_tick, lock_tick} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 000000", {state, running, paused, drop_tick, lock_tick});
        end
        rst_n = 1'b1;
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL idle_ignores_pause got %0d expected 0", state);
        end
    endtask

    task automatic test_run();
        int n;
        level = 4'd0;
        pulse_start();
        checks++;
        if (state !== 2'd1 || running !== 1'b1 || paused !== 1'b0) begin
            errors++;
            $display("FAIL run_entry got state=%0d running=%0b paused=%0b expected 1 1 0", state, running, paused);
        end
        wait_drop(100, n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL run_first_drop got %0d expected 64", n);
        end
        wait_drop(100, n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL run_second_drop got %0d expected 64", n);
        end
    endtask

    task automatic test_level();
        int n;
        level = 4'd4;
        pulse_start();
        wait_drop(100, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL level4_clamped got %0d expected 8", n);
        end
        level = 4'd0;
        pulse_start();
        for (int i = 0; i < 20; i++) step();
        level = 4'd3;
        wait_drop(100, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL level_shrink_immediate got %0d expected 1", n);
        end
        wait_drop(100, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL level3_period got %0d expected 8", n);
        end
    endtask

    task automatic test_soft_drop();
        int n;
        int bad;
        level = 4'd2;
        pulse_start();
        soft_drop = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            wait_drop(100, n);
            if (n != 4) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL soft_drop_period got %0d wrong intervals expected 0", bad);
        end
        soft_drop = 1'b0;
        wait_drop(100, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL soft_release_period got %0d expected 16", n);
        end
    endtask

    task automatic test_lock();
        int n;
        int drops;
        int locks;
        level = 4'd0;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        landed = 1'b1;
        step();
        checks++;
        if (state !== 2'd3 || running !== 1'b1) begin
            errors++;
            $display("FAIL lock_entry got state=%0d running=%0b expected 3 1", state, running);
        end
        wait_lock(30, n, drops);
        landed = 1'b0;
        checks++;
        if (n !== 10 || drops !== 0) begin
            errors++;
            $display("FAIL lock_expiry got n=%0d drops=%0d expected 10 0", n, drops);
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL lock_to_run got %0d expected 1", state);
        end
        level = 4'd4;
        pulse_start();
        for (int i = 0; i < 7; i++) step();
        landed = 1'b1;
        step();
        checks++;
        if (state !== 2'd3 || drop_tick !== 1'b0) begin
            errors++;
            $display("FAIL land_at_terminal got state=%0d drop=%0b expected 3 0", state, drop_tick);
        end
        for (int i = 0; i < 4; i++) step();
        landed = 1'b0;
        step();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL lift_off got %0d expected 1", state);
        end
        count_ticks(12, drops, locks);
        checks++;
        if (locks !== 0) begin
            errors++;
            $display("FAIL lift_off_no_lock got %0d expected 0", locks);
        end
    endtask

    task automatic test_pause();
        int n;
        int drops;
        int locks;
        level = 4'd0;
        pulse_start();
        for (int i = 0; i < 30; i++) step();
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        checks++;
        if (state !== 2'd2 || paused !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_entry got state=%0d paused=%0b running=%0b expected 2 1 0", state, paused, running);
        end
        count_ticks(100, drops, locks);
        checks++;
        if (drops + locks !== 0) begin
            errors++;
            $display("FAIL pause_silent got %0d expected 0", drops + locks);
        end
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        wait_drop(100, n);
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL pause_resume_drop got %0d expected 34", n);
        end
        pulse_start();
        landed = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        for (int i = 0; i < 20; i++) step();
        pause_toggle = 1'b1;
        step();
        pause_toggle = 1'b0;
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL resume_into_lock got %0d expected 3", state);
        end
        wait_lock(30, n, drops);
        landed = 1'b0;
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL lock_cnt_kept got %0d expected 7", n);
        end
    endtask

    task automatic test_priority();
        level = 4'd0;
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        stop = 1'b1;
        pause_toggle = 1'b1;
        step();
        stop = 1'b0;
        pause_toggle = 1'b0;
        checks++;
        if (state !== 2'd0 || paused !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL stop_over_pause got state=%0d paused=%0b expected 0 0", state, paused);
        end
        start = 1'b1;
        pause_toggle = 1'b1;
        step();
        start = 1'b0;
        pause_toggle = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL start_over_pause got %0d expected 1", state);
        end
        level = 4'd4;
        pulse_start();
        for (int i = 0; i < 7; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (state !== 2'd0 || drop_tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_suppresses_drop got state=%0d drop=%0b expected 0 0", state, drop_tick);
        end
    endtask

`ifdef DROP_TICK_COUNT_EN
    task automatic test_drop_count();
        int n;
        level = 4'd4;
        pulse_start();
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL drop_count_clear got %0d expected 0", drop_count);
        end
        for (int i = 0; i < 3; i++) wait_drop(100, n);
        checks++;
        if (drop_count !== 16'd3) begin
            errors++;
            $display("FAIL drop_count_three got %0d expected 3", drop_count);
        end
    endtask
`endif

    task automatic test_async_reset();
        level = 4'd0;
        pulse_start();
        landed = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, running, paused, drop_tick, lock_tick} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got %b expected 000000", {state, running, paused, drop_tick, lock_tick});
        end
        landed = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        pause_toggle = 1'b0;
        soft_drop    = 1'b0;
        level        = 4'd0;
        landed       = 1'b0;
        test_reset();
        test_run();
        test_level();
        test_soft_drop();
`ifdef DROP_TICK_COUNT_EN
        test_drop_count();
`endif
        test_lock();
        test_pause();
        test_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
